keypad_matrix_scan: RTL and testbench

Parametrised successor of the fixed 5x4 keypad scanner. Drives an active-low column strobe across a ROWS x COLS matrix and samples the active-low rows through a 2-flop synchroniser. Each key is debounced independently over several scans. Press and release events go into a small FIFO behind a valid/ready handshake, and a debounced bitmap of all key states is also kept. It sits between the board keypad pins and the front-panel control logic.

---
 rtl/keypad_matrix_scan_if.sv | 35 +++
 rtl/keypad_matrix_scan.sv | 254 +++++++++++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_scan_if.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scan_if
// Event handshake between the keypad scanner (master) and the front-panel
// consumer (slave). The head of the scanner's event FIFO is presented here.
//
// Signals:
//   evt_valid  master->slave  event FIFO non-empty
//   evt_code   master->slave  key index of the head event (col*ROWS+row)
//   evt_press  master->slave  1 = press event, 0 = release event
//   evt_ready  slave->master  consumer accepts the head event this cycle
// -----------------------------------------------------------------------------
interface keypad_matrix_scan_if #(
  parameter int CW = 5
) ();

  logic          evt_valid;
  logic [CW-1:0] evt_code;
  logic          evt_press;
  logic          evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_press,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_press,
    output evt_ready
  );

endinterface

// File: rtl/keypad_matrix_scan.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scan
// Scans a ROWS x COLS key matrix with an active-low one-cold column strobe,
// samples the active-low rows through a 2-flop synchroniser, debounces every
// key independently over several scans and queues press/release events in a
// small first-word-through FIFO. A debounced bitmap of all keys is kept too.
//
// Scan timing per column: DRIVE phase (SETTLE cycles, rows captured on the
// last one) followed by a PROC phase (ROWS cycles, one key per cycle).
//
// Ports:
//   clk       system clock
//   rstn      asynchronous active-low reset
//   key_row   row inputs, 0 = pressed key on the driven column
//   key_col   column strobe, active-low one-cold (all ones while idle)
//   key_data  debounced key state, 1 = pressed, bit index = col*ROWS+row
//   evt       event handshake (master side): valid/code/press out, ready in
//   overflow  sticky flag, an event was dropped because the FIFO was full
//   ovf_clr   clears overflow (a drop in the same cycle wins)
// -----------------------------------------------------------------------------
module keypad_matrix_scan #(
  parameter int ROWS       = 5,
  parameter int COLS       = 4,
  parameter int SETTLE     = 3,
  parameter int DEB_SCANS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ROWS-1:0]        key_row,
  output logic [COLS-1:0]        key_col,
  output logic [ROWS*COLS-1:0]   key_data,
  keypad_matrix_scan_if.master   evt,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int KEYS = ROWS * COLS;
  localparam int CW   = $clog2(KEYS);
  // Phase counter must reach both SETTLE-1 and ROWS-1.
  localparam int PHW  = $clog2((SETTLE > ROWS) ? SETTLE : ROWS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW = $clog2(COLS);
  localparam int DW   = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Scan sequencer FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,   // out of reset, strobe not yet driven
    S_DRIVE,  // column driven, rows settling through the synchroniser
    S_PROC    // one captured row bit processed per cycle
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PHW-1:0]   phase_cnt;
  logic [COLW-1:0]  col_idx;
  logic             drive_done;
  logic             proc_done;
  logic             capture_en;
  logic             proc_en;
  logic             col_adv;

  assign drive_done = (state == S_DRIVE) && (phase_cnt == PHW'(SETTLE - 1));
  assign proc_done  = (state == S_PROC)  && (phase_cnt == PHW'(ROWS - 1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // values from before the edge, independent of block ordering.
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_DRIVE;
      S_DRIVE: if (drive_done) state_nxt = S_PROC;
      S_PROC:  if (proc_done)  state_nxt = S_DRIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    key_col    = '1;
    capture_en = 1'b0;
    proc_en    = 1'b0;
    col_adv    = 1'b0;
    unique case (state)
      S_IDLE: begin
        key_col = '1;
      end
      S_DRIVE: begin
        key_col    = ~(COLS'(1) << col_idx);
        capture_en = drive_done;
      end
      S_PROC: begin
        key_col = ~(COLS'(1) << col_idx);
        proc_en = 1'b1;
        col_adv = proc_done;
      end
      default: key_col = '1;
    endcase
  end

  // Phase and column counters. The phase counter restarts at every phase
  // boundary; the column advances (with wrap) at the end of each PROC phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_cnt <= '0;
      col_idx   <= '0;
    end else if (state == S_IDLE) begin
      phase_cnt <= '0;
      col_idx   <= '0;
    end else if (drive_done || proc_done) begin
      phase_cnt <= '0;
      if (col_adv) begin
        col_idx <= (col_idx == COLW'(COLS - 1)) ? '0 : col_idx + 1'b1;
      end
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Row synchroniser and capture
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] sync1;
  logic [ROWS-1:0] sync2;
  logic [ROWS-1:0] row_cap;   // 1 = pressed, for the current column

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= '1;
      sync2   <= '1;
      row_cap <= '0;
    end else begin
      sync1 <= key_row;
      sync2 <= sync1;
      if (capture_en) begin
        row_cap <= ~sync2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce. Exactly one key is visited per PROC cycle, so a single
  // read/modify/write port on the counter array suffices.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  deb_cnt [KEYS];
  logic [RW-1:0]  row_idx;
  logic [CW-1:0]  key_idx;
  logic           sample;
  logic           cur_state;
  logic [DW-1:0]  cur_cnt;
  logic           deb_hit;
  logic           push;

  assign row_idx   = RW'(phase_cnt);
  assign key_idx   = CW'(int'(col_idx) * ROWS + int'(row_idx));
  assign sample    = row_cap[row_idx];
  assign cur_state = key_data[key_idx];
  assign cur_cnt   = deb_cnt[key_idx];
  assign deb_hit   = (cur_cnt == DW'(DEB_SCANS - 1));
  // A key flips (and reports) only after DEB_SCANS consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  assign push      = proc_en && (sample != cur_state) && deb_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_data <= '0;
      for (int k = 0; k < KEYS; k++) begin
        deb_cnt[k] <= '0;
      end
    end else if (proc_en) begin
      if (sample == cur_state) begin
        deb_cnt[key_idx] <= '0;
      end else if (deb_hit) begin
        key_data[key_idx] <= sample;
        deb_cnt[key_idx]  <= '0;
      end else begin
        deb_cnt[key_idx] <= cur_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO, first-word-through. Pointers carry one extra wrap bit so
  // full and empty are distinguishable without a separate count.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] mem_code  [FIFO_DEPTH];
  logic          mem_press [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && evt.evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // NOTE: the storage array has no reset; entries are only observable while
  // evt_valid is high, and the head outputs are forced to zero when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_code[wr_ptr[AW-1:0]]  <= key_idx;
      mem_press[wr_ptr[AW-1:0]] <= sample;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign evt.evt_valid = !empty;
  assign evt.evt_code  = empty ? '0   : mem_code[rd_ptr[AW-1:0]];
  assign evt.evt_press = empty ? 1'b0 : mem_press[rd_ptr[AW-1:0]];

  // Sticky overflow; a drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scan
// Drives a simulated key matrix and a randomly stalling consumer, and compares
// the scanner against a scan-level reference model: per full scan the model
// applies the debounce rule to every key, schedules the resulting events at
// their PROC cycle, and tracks the event FIFO as a bounded queue.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scan;

  localparam int ROWS   = 5;
  localparam int COLS   = 4;
  localparam int SETTLE = 3;
  localparam int DEB    = 3;
  localparam int DEPTH  = 4;
  localparam int K      = ROWS * COLS;
  localparam int CW     = $clog2(K);
  localparam int CP     = SETTLE + ROWS;   // column period
  localparam int SCAN   = CP * COLS;       // full scan

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [ROWS-1:0] key_row;
  logic [COLS-1:0] key_col;
  logic [K-1:0]    key_data;
  logic            overflow;
  logic            ovf_clr = 1'b0;

  keypad_matrix_scan_if #(.CW(CW)) evt ();

  keypad_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE),
    .DEB_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_data (key_data),
    .evt      (evt),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is low.
  logic [K-1:0] pressed = '0;
  always_comb begin
    key_row = '1;
    for (int c = 0; c < COLS; c++) begin
      if (key_col[c] == 1'b0) begin
        for (int r = 0; r < ROWS; r++) begin
          if (pressed[c*ROWS + r]) key_row[r] = 1'b0;
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CW-1:0] code;
    logic          press;
  } evt_t;

  logic [K-1:0] m_kd;
  int           m_cnt [K];
  evt_t         mq [$];
  bit           m_ovf;
  bit           sch_v     [SCAN];
  int           sch_code  [SCAN];
  bit           sch_press [SCAN];

  task automatic model_reset();
    m_kd  = '0;
    m_ovf = 1'b0;
    mq.delete();
    for (int k = 0; k < K; k++) m_cnt[k] = 0;
  endtask

  // Applies one full scan of the current 'pressed' pattern; each event lands
  // on the PROC cycle of its row within its column.
  task automatic model_scan();
    for (int i = 0; i < SCAN; i++) sch_v[i] = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        int  k;
        bit  s;
        k = c*ROWS + r;
        s = pressed[k];
        if (s == m_kd[k]) begin
          m_cnt[k] = 0;
        end else if (m_cnt[k] == DEB - 1) begin
          int slot;
          m_kd[k]  = s;
          m_cnt[k] = 0;
          slot = c*CP + SETTLE + r;
          sch_v[slot]     = 1'b1;
          sch_code[slot]  = k;
          sch_press[slot] = s;
        end else begin
          m_cnt[k]++;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // One full scan. Entered at #1 into cycle 0 of a scan; returns at #1 into
  // cycle 0 of the next scan, or early at cycle abort_at (left mid-scan).
  // ---------------------------------------------------------------------------
  task automatic run_scan(input logic [K-1:0] p, input int ready_pct,
                          input bit clr, input int abort_at);
    check("key_data", key_data, m_kd);
    pressed = p;
    model_scan();
    for (int i = 0; i < SCAN; i++) begin
      logic [COLS-1:0] exp_col;
      bit              rdy;
      bit              pop;
      bit              drop;
      evt_t            e;
      exp_col = ~(COLS'(1) << (i / CP));
      check("key_col", key_col, exp_col);
      check("evt_valid", evt.evt_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("evt_code", evt.evt_code, mq[0].code);
        check("evt_press", evt.evt_press, mq[0].press);
      end
      check("overflow", overflow, m_ovf);
      if (i == abort_at) return;
      rdy = ($urandom_range(99) < ready_pct);
      evt.evt_ready = rdy;
      ovf_clr = clr && (i == 0);
      // FIFO behaviour across the coming edge.
      pop  = (mq.size() != 0) && rdy;
      drop = sch_v[i] && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (sch_v[i] && !drop) begin
        e.code  = CW'(sch_code[i]);
        e.press = sch_press[i];
        mq.push_back(e);
      end
      if (drop)         m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      @(posedge clk);
      #1;
    end
    ovf_clr = 1'b0;
  endtask

  task automatic hold(input logic [K-1:0] p, input int n, input int ready_pct);
    for (int s = 0; s < n; s++) run_scan(p, ready_pct, 1'b0, -1);
  endtask

  // Asynchronous reset; leaves the bench at #1 into cycle 0 of scan 0.
  task automatic apply_reset();
    rstn          = 1'b0;
    pressed       = '0;
    evt.evt_ready = 1'b0;
    ovf_clr       = 1'b0;
    #1;
    check("rst_key_col", key_col, {COLS{1'b1}});
    check("rst_evt_valid", evt.evt_valid, 1'b0);
    check("rst_evt_code", evt.evt_code, '0);
    check("rst_evt_press", evt.evt_press, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_key_data", key_data, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_key_col", key_col, {COLS{1'b1}});
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("idle_key_col", key_col, {COLS{1'b1}});
    @(posedge clk);
    #1;
  endtask

  initial begin
    evt.evt_ready = 1'b0;
    #2;
    apply_reset();

    // Idle scan.
    hold('0, 1, 100);

    // Single key col2/row0 (index 10): press then release.
    hold(K'(1) << 10, 4, 100);
    hold('0, 4, 100);

    // Bounces shorter than DEB scans; a release in between restarts the count.
    hold(K'(1) << 10, 2, 100);
    hold('0, 1, 100);
    hold(K'(1) << 10, 2, 100);
    hold('0, 2, 100);

    // Rows 1 and 3 on column 0 together.
    hold(K'('hA), 3, 100);
    check("key_data_rows13", key_data, 32'h0000A);
    hold('0, 3, 100);

    // Five presses with a stalled consumer: four queued, one dropped.
    hold(K'('h1F), 4, 0);
    hold(K'('h1F), 2, 100);
    run_scan(K'('h1F), 100, 1'b1, -1);
    hold('0, 3, 100);

    // Randomised patterns, hold lengths and consumer behaviour.
    for (int seg = 0; seg < 14; seg++) begin
      logic [K-1:0] p;
      int           n;
      int           rp;
      p  = K'($urandom) & K'($urandom);
      n  = $urandom_range(1, 4);
      case ($urandom_range(3))
        0:       rp = 0;
        1:       rp = 30;
        2:       rp = 70;
        default: rp = 100;
      endcase
      for (int s = 0; s < n; s++) begin
        run_scan(p, rp, ($urandom_range(5) == 0), -1);
      end
    end
    hold('0, 4, 100);

    // Reset in the middle of a PROC phase with two events queued.
    hold(K'('hA), 3, 0);
    run_scan(K'('hA), 0, 1'b0, CP + SETTLE + 2);
    apply_reset();
    hold('0, 1, 100);
    hold(K'(1) << 7, 3, 100);
    hold('0, 4, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
